period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the period and high time of a slow, asynchronous square wave, counted in `clk` cycles.
- Typical input is a divided clock such as the 100 Hz `s_clk` from a 100 MHz system clock.
- Performs the inverse job of the frequency divider: a slow clock goes in, cycle counts come out, so software and bench can confirm the divided rate.
- Sits in the fast `clk` domain, between any slow-tick source and the status/display logic.

Parameters:
- CNT_W, 20, width of all counters and results; covers 1,000,000 cycles.
- MAX_CNT, 20'd1048575, largest period accepted; a longer period raises `timeout`.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- s_in  input  1  asynchronous slow square wave to measure.
- period  output  CNT_W  clk cycles between the last two `s_in` rising edges.
- high_time  output  CNT_W  clk cycles `s_in` was high within that period.
- valid  output  1  one-cycle pulse when `period` and `high_time` update.
- timeout  output  1  level; no rising edge seen within MAX_CNT cycles.
- locked  output  1  level; at least one valid measurement since reset or timeout.

Behaviour:
- Reset (`reset`=0, asynchronous): all registers clear, state = IDLE.
  - Outputs `period`=0, `high_time`=0, `valid`=0, `timeout`=0, `locked`=0.
  - Release from reset is synchronous to `clk`.
- Input synchronizer:
  - `s_in` passes through 2 flops (s1, s2), then a third flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Latency: `s_in` sampled high at clk edge k gives rise at edge k+2; the matching `valid` is high in the cycle after edge k+3.
- Counter `cnt`:
  - Cleared to 0 on every rise.
  - Otherwise increments by 1 per cycle.
  - In TIMEOUT it holds its value and does not wrap.
- On fall: `hi_pend` <= `cnt` + 1.
- State machine:
  - IDLE: wait for rise → MEASURE with `cnt` <= 0. No `valid` is produced on this first edge.
  - MEASURE, on rise: `period` <= `cnt` + 1, `high_time` <= `hi_pend`, `valid` <= 1 for one cycle, `locked` <= 1, `cnt` <= 0.
  - MEASURE, `cnt` == MAX_CNT−1 with no rise: → TIMEOUT, `timeout` <= 1, `locked` <= 0, `period`/`high_time` <= 0, no `valid`.
  - TIMEOUT, on rise: `timeout` <= 0, `cnt` <= 0, → MEASURE (re-arm). The first edge after a timeout does not produce `valid`.
- Boundary cases:
  - Rise in the same cycle that `cnt` hits MAX_CNT−1: the rise wins, giving a valid measurement with `period` = MAX_CNT.
  - No fall seen within a period (input held high): `high_time` reports the stale `hi_pend`. `hi_pend` is cleared to 0 on each rise and on timeout.
  - Minimum period is 2 cycles; shorter pulses are lost by the synchronizer and not flagged.
  - Outputs hold between `valid` pulses.
  - `reset` asserted mid-measurement aborts immediately; behaviour after release is identical to power-up.

Decomposition:
- Shared package `period_meter_pkg`:
  - State encoding constants IDLE=2'd0, MEASURE=2'd1, TIMEOUT=2'd2.
  - Default CNT_W/MAX_CNT.
- Sub-module `sync_edge_detect`: contains the 2-flop synchronizer plus the s3 flop; outputs `rise`, `fall` and the synchronized level. It is reusable for the push buttons elsewhere in the design.

Test Plan:
- Reset: hold `reset`=0 while toggling `s_in` → all outputs 0. Release, then first rise → no `valid`, `locked`=0.
- Nominal (defaults): `s_in` 100 Hz at 50% duty from 100 MHz (toggle every 500000 clk) → from the second rise onward each `valid` shows `period`=1000000, `high_time`=500000, `locked`=1, `valid` exactly 1 cycle wide.
- Short duty (CNT_W=8, MAX_CNT=200): `s_in` high 3 cycles, low 7 cycles → `period`=10, `high_time`=3 each period. Minimum case of 1 high / 1 low → `period`=2, `high_time`=1.
- Timeout (CNT_W=8, MAX_CNT=200): stop `s_in` low after locking → exactly 200 cycles after the last rise `timeout`=1, `locked`=0, `period`=0. Restart the 10-cycle wave → first rise clears `timeout` with no `valid`; next rise gives `valid` with `period`=10.
- Boundary: rises spaced exactly MAX_CNT=200 cycles apart → `valid` with `period`=200 and no `timeout`. Spacing 201 → `timeout`.
- Reset mid-op: assert `reset` halfway through a period → outputs 0 within the same cycle (asynchronous). After release → IDLE behaviour as in the reset scenario.

Source files
------------

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared definitions for the period meter.
//   - state_t     : FSM state encoding (IDLE, MEASURE, TIMEOUT)
//   - DEF_CNT_W   : default counter/result width
//   - DEF_MAX_CNT : default longest accepted period, in clk cycles
package period_meter_pkg;

    localparam int unsigned DEF_CNT_W   = 20;
    localparam int unsigned DEF_MAX_CNT = 1048575;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the clk domain and
// flags its edges.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   din   : asynchronous input level
//   rise  : one-cycle pulse after a synchronized 0->1 transition
//   fall  : one-cycle pulse after a synchronized 1->0 transition
//   level : synchronized level (output of the second flop)
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic s1_q, s2_q, s3_q;
    logic rise_q, fall_q;

    // s1/s2 form the metastability filter; s3 delays s2 by one cycle for
    // edge detection. The edge pulses are registered so downstream logic
    // sees clean flop outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise  = rise_q;
    assign fall  = fall_q;
    assign level = s2_q;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous
// square wave in clk cycles.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   s_in      : asynchronous slow square wave
//   period    : clk cycles between the last two s_in rising edges
//   high_time : clk cycles s_in was high within that period
//   valid     : one-cycle pulse when period/high_time update
//   timeout   : level, no rising edge within MAX_CNT cycles
//   locked    : level, a valid measurement since reset or timeout
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MAX_CNT = DEF_MAX_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CNT - 1);

    logic rise, fall, level_unused;

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (s_in),
        .rise  (rise),
        .fall  (fall),
        .level (level_unused)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_pend_q, hi_pend_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_pend_q <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_pend_q <= hi_pend_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_pend_d = hi_pend_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        locked_d  = locked_q;

        // cnt counts from 0 after the rise, so the fall edge closes a high
        // phase of cnt+1 cycles.
        if (fall) begin
            hi_pend_d = cnt_q + CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                // First edge only starts the count; there is no prior edge
                // to measure against.
                if (rise) begin
                    state_d   = MEASURE;
                    cnt_d     = '0;
                    hi_pend_d = '0;
                end
            end
            MEASURE: begin
                // Rise takes priority so a period of exactly MAX_CNT is
                // still a valid measurement.
                if (rise) begin
                    period_d  = cnt_q + CNT_ONE;
                    high_d    = hi_pend_q;
                    valid_d   = 1'b1;
                    locked_d  = 1'b1;
                    cnt_d     = '0;
                    hi_pend_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    period_d  = '0;
                    high_d    = '0;
                    hi_pend_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TIMEOUT: begin
                // cnt holds here; a rise only re-arms the measurement.
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    hi_pend_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed bench for period_meter with CNT_W=8, MAX_CNT=200.
module tb_period_meter;

    logic       clk;
    logic       reset;
    logic       s_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       valid;
    logic       timeout;
    logic       locked;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered every cycle by step().
    int         vcount     = 0;
    int         width_err  = 0;
    logic       prev_valid = 1'b0;
    logic       to_seen    = 1'b0;
    logic [7:0] last_p     = '0;
    logic [7:0] last_h     = '0;

    period_meter #(
        .CNT_W   (8),
        .MAX_CNT (200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive s_in for one clock, then sample outputs 1 ns after the edge.
    task automatic step(input logic v);
        s_in = v;
        @(posedge clk);
        #1;
        if (valid) begin
            vcount++;
            last_p = period;
            last_h = high_time;
            if (prev_valid) width_err++;
        end
        prev_valid = valid;
        if (timeout) to_seen = 1'b1;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            repeat (hi) step(1'b1);
            repeat (lo) step(1'b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        s_in  = 1'b0;

        // Reset held while s_in toggles: everything stays cleared.
        for (int i = 0; i < 6; i++) step(i[0] == 1'b0);
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_locked", 32'(locked), 0);

        // Release; first rise gives no measurement.
        reset = 1'b1;
        repeat (3) step(1'b0);
        vcount = 0;
        wave(3, 7, 1);
        chk("first_rise_novalid", 32'(vcount), 0);
        chk("first_rise_unlocked", 32'(locked), 0);

        // 3 high / 7 low: period 10, high 3.
        wave(3, 7, 3);
        chk("duty_vcount", 32'(vcount), 3);
        chk("duty_period", 32'(last_p), 10);
        chk("duty_high", 32'(last_h), 3);
        chk("duty_locked", 32'(locked), 1);
        chk("duty_width", 32'(width_err), 0);

        // Minimum 1 high / 1 low: period 2, high 1.
        wave(1, 1, 8);
        chk("min_period", 32'(last_p), 2);
        chk("min_high", 32'(last_h), 1);
        chk("min_width", 32'(width_err), 0);

        // Lock, then hold low: timeout lands 200 cycles after the last rise
        // is seen by the FSM (3 cycles after s_in is first sampled high).
        wave(3, 7, 3);
        repeat (193) step(1'b0);
        chk("pre_timeout", 32'(timeout), 0);
        chk("pre_timeout_locked", 32'(locked), 1);
        step(1'b0);
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_unlocked", 32'(locked), 0);
        chk("timeout_period", 32'(period), 0);
        chk("timeout_high", 32'(high_time), 0);

        // Restart: first rise only clears timeout, second measures.
        vcount = 0;
        wave(3, 7, 1);
        chk("rearm_novalid", 32'(vcount), 0);
        chk("rearm_timeout_clr", 32'(timeout), 0);
        chk("rearm_unlocked", 32'(locked), 0);
        vcount = 0;
        wave(3, 7, 1);
        chk("rearm_vcount", 32'(vcount), 1);
        chk("rearm_period", 32'(last_p), 10);
        chk("rearm_high", 32'(last_h), 3);
        chk("rearm_locked", 32'(locked), 1);

        // Rises exactly MAX_CNT apart: valid, no timeout.
        to_seen = 1'b0;
        wave(1, 199, 2);
        chk("bound200_period", 32'(last_p), 200);
        chk("bound200_high", 32'(last_h), 1);
        chk("bound200_no_timeout", 32'(to_seen), 0);

        // Spacing 201 times out; the following rise re-arms without valid.
        to_seen = 1'b0;
        wave(1, 200, 2);
        chk("bound201_timeout_seen", 32'(to_seen), 1);
        chk("bound201_period", 32'(period), 0);
        chk("bound201_unlocked", 32'(locked), 0);
        chk("bound201_timeout_clr", 32'(timeout), 0);

        // Relock, then assert reset mid-period between clock edges.
        wave(3, 7, 3);
        chk("mid_locked_before", 32'(locked), 1);
        repeat (3) step(1'b1);
        repeat (2) step(1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_period", 32'(period), 0);
        chk("async_high", 32'(high_time), 0);
        chk("async_valid", 32'(valid), 0);
        chk("async_timeout", 32'(timeout), 0);
        chk("async_locked", 32'(locked), 0);
        repeat (3) step(1'b0);

        reset = 1'b1;
        repeat (3) step(1'b0);
        vcount = 0;
        wave(3, 7, 1);
        chk("post_rst_novalid", 32'(vcount), 0);
        chk("post_rst_unlocked", 32'(locked), 0);
        wave(3, 7, 1);
        chk("post_rst_vcount", 32'(vcount), 1);
        chk("post_rst_period", 32'(last_p), 10);
        chk("post_rst_locked", 32'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
